// File: rtl/key_entry_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_entry_pkg
//  Description : Shared types and defaults for the key_entry block: the
//                debounce FSM state encoding, default cycle counts and a
//                helper that picks the lowest-numbered pressed button.
//  Revision    : 1.0  initial release
// ============================================================================
package key_entry_pkg;

    // Debouncer state encoding.
    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_DEB_PRESS   = 2'd1,
        ST_HELD        = 2'd2,
        ST_DEB_RELEASE = 2'd3
    } state_t;

    // 10 ms and 5 s at a 50 MHz clock.
    localparam int unsigned C_DEBOUNCE_DEFAULT = 500000;
    localparam int unsigned C_TIMEOUT_DEFAULT  = 250000000;

    // Index of the lowest set bit; only meaningful when pressed != 0.
    function automatic logic [1:0] lowest_index(input logic [3:0] pressed);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pressed[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_entry_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : sync2
//  Description : Two-flop synchronizer for asynchronous level inputs.
//  Revision    : 1.0  initial release
//  Ports       : clk  - destination clock
//                rst  - asynchronous active-low reset (loads RESET_VAL)
//                d    - asynchronous input bus
//                q    - synchronized output bus
// ============================================================================
module sync2 #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] stage1_d;
    logic [WIDTH-1:0] stage2_q;
    logic [WIDTH-1:0] stage2_d;

    always_comb begin
        stage1_d = d;
        stage2_d = stage1_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage1_q <= RESET_VAL;
            stage2_q <= RESET_VAL;
        end else begin
            stage1_q <= stage1_d;
            stage2_q <= stage2_d;
        end
    end

    assign q = stage2_q;

endmodule
`default_nettype wire

// File: rtl/key_entry.sv
`default_nettype none
// ============================================================================
//  Module      : key_entry
//  Description : Debounced 4-button key entry. Accepts one press at a time
//                (lowest-numbered button wins), emits a one-hot one-cycle
//                enable pulse and captures the digit switches with it.
//                Optional inactivity timeout when KEY_ENTRY_TIMEOUT_EN is
//                defined; otherwise timeout is tied low.
//  Revision    : 1.0  initial release
//  Ports       : clk     - system clock, rising edge
//                rst     - asynchronous active-low reset
//                btn_n   - raw active-low push-buttons (async)
//                sw      - raw digit switches (async)
//                enable  - one-hot pulse per accepted press
//                digit   - switch value captured at accepted press
//                busy    - state != IDLE
//                timeout - one-cycle inactivity pulse
// ============================================================================
module key_entry
    import key_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = C_DEBOUNCE_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES  = C_TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_n,
    input  logic [3:0] sw,
    output logic [3:0] enable,
    output logic [3:0] digit,
    output logic       busy,
    output logic       timeout
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("key_entry: DEBOUNCE_CYCLES must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("key_entry: TIMEOUT_CYCLES must be at least 1");
    end

    // ------------------------------------------------------------------
    // Input synchronizers. Buttons reset to "released" so a button held
    // through reset is seen as a fresh press once reset lifts.
    // ------------------------------------------------------------------
    logic [3:0] btn_n_s;
    logic [3:0] sw_s;

    sync2 #(.WIDTH(4), .RESET_VAL(4'hF)) u_sync_btn (
        .clk (clk),
        .rst (rst),
        .d   (btn_n),
        .q   (btn_n_s)
    );

    sync2 #(.WIDTH(4), .RESET_VAL(4'h0)) u_sync_sw (
        .clk (clk),
        .rst (rst),
        .d   (sw),
        .q   (sw_s)
    );

    logic [3:0] pressed;
    logic       any_pressed;

    assign pressed     = ~btn_n_s;
    assign any_pressed = |pressed;

    // ------------------------------------------------------------------
    // Debounce FSM with one shared counter for press and release.
    // ------------------------------------------------------------------
    state_t           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [1:0]       sel_q,    sel_d;
    logic [3:0]       enable_q, enable_d;
    logic [3:0]       digit_q,  digit_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        enable_d = 4'h0;
        digit_d  = digit_q;
        case (state_q)
            ST_IDLE: begin
                if (any_pressed) begin
                    sel_d   = lowest_index(pressed);
                    cnt_d   = '0;
                    state_d = ST_DEB_PRESS;
                end
            end
            ST_DEB_PRESS: begin
                if (!pressed[sel_q]) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    enable_d = 4'(1) << sel_q;
                    digit_d  = sw_s;
                    state_d  = ST_HELD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HELD: begin
                // Every button must be up before the release is debounced,
                // so secondary buttons cannot sneak in a second pulse.
                if (!any_pressed) begin
                    cnt_d   = '0;
                    state_d = ST_DEB_RELEASE;
                end
            end
            ST_DEB_RELEASE: begin
                if (any_pressed) begin
                    cnt_d   = '0;
                    state_d = ST_HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sel_q    <= 2'd0;
            enable_q <= 4'h0;
            digit_q  <= 4'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            enable_q <= enable_d;
            digit_q  <= digit_d;
        end
    end

    assign enable = enable_q;
    assign digit  = digit_q;
    assign busy   = (state_q != ST_IDLE);

    // ------------------------------------------------------------------
    // Optional inactivity timeout.
    // ------------------------------------------------------------------
`ifdef KEY_ENTRY_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_FULL = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q,  to_cnt_d;
    logic            timeout_q, timeout_d;

    // The counter parks at TIMEOUT_CYCLES once expired. Resetting it to that
    // parked value means nothing fires until the first accepted press.
    always_comb begin
        to_cnt_d  = to_cnt_q;
        timeout_d = 1'b0;
        if (|enable_q) begin
            to_cnt_d = '0;
        end else if ((state_q == ST_IDLE) && (to_cnt_q != TO_FULL)) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
            if (to_cnt_q == TO_LAST) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q  <= TO_FULL;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/key_entry.md
KEY_ENTRY -- requirements
Module: key_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, 500000, stable-level cycles required to accept a press or release (10 ms at 50 MHz); legal minimum 2.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, 250000000, idle cycles after an accepted press before timeout fires (5 s at 50 MHz).
REQ-003 SHALL have ports, in this order:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- btn_n  input  4  raw push-buttons, active-low, asynchronous to clk.
- sw  input  4  raw digit switches, asynchronous to clk.
- enable  output  4  one-hot, one-cycle pulse per accepted press; feeds the password checker's per-digit enables.
- digit  output  4  switch value captured at the accepted press; held until the next press.
- busy  output  1  high whenever state is not IDLE.
- timeout  output  1  one-cycle inactivity pulse.

Function
REQ-004 SHALL pass btn_n and sw through 2-flop synchronizers; all later logic uses synchronized values only; button pressed means synchronized btn_n bit = 0.
REQ-005 SHALL implement states IDLE, DEB_PRESS, HELD, DEB_RELEASE with one shared counter of width clog2(DEBOUNCE_CYCLES).
REQ-006 IDLE: on any pressed button, latch index sel of the lowest-numbered pressed button, clear counter, go to DEB_PRESS.
REQ-007 DEB_PRESS: while button sel is pressed, increment counter; at count DEBOUNCE_CYCLES-1, pulse enable[sel] for exactly one cycle, load digit from synchronized sw in the same cycle, go to HELD.
REQ-008 DEB_PRESS: if button sel releases before terminal count, return to IDLE with no enable pulse and digit unchanged.
REQ-009 HELD: no pulses; when all four buttons are released, clear counter and go to DEB_RELEASE.
REQ-010 DEB_RELEASE: increment while all buttons are released; any press clears counter and returns to HELD; at DEBOUNCE_CYCLES-1, go to IDLE.
REQ-011 Latency from first clock edge sampling btn_n low (stable) to enable pulse SHALL be exactly DEBOUNCE_CYCLES+3 cycles.
REQ-012 Simultaneous presses: only the lowest index is accepted; other buttons are ignored until all buttons are released and the release has debounced.
REQ-013 At most one enable bit SHALL be high in any cycle; one physical press SHALL yield at most one pulse.
REQ-014 busy SHALL be combinational decode of state != IDLE.

Reset
REQ-015 rst low SHALL asynchronously force state IDLE, counters 0, synchronizer flops 1 for btn_n and 0 for sw, enable 0, digit 0, busy 0, timeout 0.
REQ-016 Reset mid-debounce SHALL discard the pending press; a button held through reset release SHALL be debounced as a new press.

Configuration
REQ-017 With KEY_ENTRY_TIMEOUT_EN defined: a counter of width clog2(TIMEOUT_CYCLES+1) clears on every enable pulse and counts while state is IDLE; at TIMEOUT_CYCLES it pulses timeout once, then holds and does not re-arm until the next enable pulse; no timeout before the first accepted press after reset.
REQ-018 Without KEY_ENTRY_TIMEOUT_EN: timeout SHALL be tied to 0 and no timeout counter SHALL be synthesized.

Structure
REQ-019 Package key_entry_pkg SHALL hold the state enum type and default constants for DEBOUNCE_CYCLES and TIMEOUT_CYCLES.
REQ-020 A sub-module sync2 (parameterized width and reset value, 2-flop synchronizer) SHALL be instantiated twice, once for btn_n and once for sw.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20)
REQ-021 With sw=7, btn_n=4'b1101 held 20 cycles: one enable=4'b0010 pulse exactly 7 cycles after the first low sample, digit=7; busy high until 4 cycles after release plus sync.
REQ-022 btn_n[0] low for 2 cycles, then high: no enable pulse, digit unchanged, state returns to IDLE.
REQ-023 btn_n=4'b0110 held (buttons 0 and 3 pressed together): only enable[0] pulses; a later release of button 0 alone while button 3 is still held produces no pulse.
REQ-024 Bouncy release (1-cycle low glitches every 3 cycles for 12 cycles): exactly one enable pulse total; busy falls only after 4 clean released cycles.
REQ-025 rst pulsed low during DEB_PRESS: all outputs 0 immediately; holding the button afterward yields one pulse 7 cycles after reset release.
REQ-026 KEY_ENTRY_TIMEOUT_EN defined: after one accepted press and release, timeout pulses once 20 IDLE cycles later and not again; a new press re-arms it; undefined: timeout stays 0 throughout.
